dmem_responder: RTL

Memory-side responder of the data-cache refill/write-back interface. It holds the 256-bit-line backing store behind the data cache, accepts one line read or line write request at a time, and completes it after a fixed, parameterised latency with a one-cycle acknowledge. It models off-chip memory for the pipelined CPU, so cache-miss stalls have realistic multi-cycle cost.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_line_ram.sv | 34 +++
 rtl/dmem_responder.sv | 88 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Types and line geometry shared by the data-memory responder and the data cache.
package dmem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_BITS    = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

endpackage

// File: rtl/dmem_line_ram.sv
// Line-wide backing store with one synchronous read/write port.
// The read register holds the last line read until the next read.
module dmem_line_ram
  import dmem_pkg::*;
#(
  parameter  int DEPTH    = 512,
  localparam int IDX_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [IDX_BITS-1:0]  idx_i,
  input  logic [LINE_BITS-1:0] wdata_i,
  output logic [LINE_BITS-1:0] rdata_o
);

  logic [LINE_BITS-1:0] memory [DEPTH];
  logic [LINE_BITS-1:0] r_rdata;

  // NOTE: the array is deliberately not reset; clearing it would wipe preloaded
  // contents and prevent mapping onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (we_i) memory[idx_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     r_rdata <= '0;
    else if (re_i) r_rdata <= memory[idx_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for data-cache line refills and write-backs.
// One request in flight; completes LATENCY cycles after acceptance with a one-cycle ack.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o,
  output logic                 busy_o
);

  localparam int IDX_BITS = $clog2(DEPTH);

  state_t                r_state;
  state_t                w_next_state;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [IDX_BITS-1:0]   r_idx;
  logic                  r_write;
  logic [LINE_BITS-1:0]  r_wdata;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_unused_addr;

  assign w_accept = (r_state == IDLE) && enable_i;
  assign w_access = (r_state == WAIT) && (r_cnt == '0);

  // Offset and bits above the line index are dropped, so addresses wrap.
  assign w_unused_addr = ^{addr_i[ADDR_BITS-1:IDX_BITS+OFFSET_BITS], addr_i[OFFSET_BITS-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_next_state = WAIT;
      WAIT:    if (r_cnt == '0) w_next_state = ACK;
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= CNT_BITS'(LATENCY - 1);
      r_idx   <= addr_i[IDX_BITS+OFFSET_BITS-1:OFFSET_BITS];
      r_write <= write_i;
      r_wdata <= data_i;
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  dmem_line_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (w_access && r_write),
    .re_i   (w_access && !r_write),
    .idx_i  (r_idx),
    .wdata_i(r_wdata),
    .rdata_o(data_o)
  );

  assign ack_o  = (r_state == ACK);
  assign busy_o = (r_state != IDLE);

endmodule
